// File: rtl/fp_pkg.sv
// Shared floating-point helpers, types and the packed IEEE754 word layout
// used by the FP pipeline stages.
`define FP_IEEE754_T(NX, NM) struct packed { logic sign; logic [(NX)-1:0] exp; logic [(NM)-1:0] mant; }

package fp;

    function automatic int unsigned EXP_OFFSET(input int unsigned nx);
        return (32'd1 << (nx - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned MAX(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned MIN(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned CLOG2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
        end
        return r;
    endfunction

    // Shared by the iterative FP stages.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_from_int_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated mantissa with guard and sticky bits.
module fp_round_rne
    import fp::*;
#(
    parameter int unsigned NM = 23
) (
    input  logic [NM-1:0] m,
    input  logic          g,
    input  logic          s,
    output logic [NM-1:0] mant_c,
    output logic          carry_c,
    output logic          inexact_c
);

    logic inc_c;

    // Ties go to the even mantissa; a full-scale increment wraps to zero with carry.
    always_comb begin
        inc_c                = g && (s || m[0]);
        {carry_c, mant_c}    = {1'b0, m} + (NM + 1)'(inc_c);
        inexact_c            = g || s;
    end

endmodule

// File: rtl/fp_from_int.sv
// Iterative integer to IEEE754 converter: normalises one bit per cycle,
// then rounds to nearest-even; one conversion in flight.
module fp_from_int
    import fp::*;
#(
    parameter int unsigned INW    = 32,
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned NX     = 8,
    parameter int unsigned NM     = 23
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INW-1:0]      in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NX+NM:0]      out_data,
    output logic                out_inexact
);

    localparam int unsigned OW       = NX + NM + 1;
    localparam int unsigned LOW      = INW - 1;
    localparam int unsigned PW       = LOW + NM + 2;
    localparam int unsigned EXP_INIT = EXP_OFFSET(NX) + INW - 1;

    typedef `FP_IEEE754_T(NX, NM) fp_word_t;

    fp_from_int_state_t state_q, state_d;
    logic               sign_q, sign_d;
    logic [INW-1:0]     mag_q, mag_d;
    logic [NX-1:0]      exp_q, exp_d;
    logic [OW-1:0]      out_data_q, out_data_d;
    logic               out_inexact_q, out_inexact_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [PW-1:0]      pad_c;
    logic [NM-1:0]      m_c, m_rnd_c;
    logic               g_c, s_c, carry_c, inexact_c;
    fp_word_t           word_c;

    // Bits below the leading one, zero-padded so narrow inputs give g=s=0.
    always_comb begin
        pad_c = {mag_q[INW-2:0], {(NM + 2){1'b0}}};
        m_c   = pad_c[PW-1 -: NM];
        g_c   = pad_c[PW-1-NM];
        s_c   = |pad_c[PW-2-NM:0];
    end

    fp_round_rne #(
        .NM (NM)
    ) u_round (
        .m         (m_c),
        .g         (g_c),
        .s         (s_c),
        .mant_c    (m_rnd_c),
        .carry_c   (carry_c),
        .inexact_c (inexact_c)
    );

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        mag_d         = mag_q;
        exp_d         = exp_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        word_c        = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = SIGNED && in_data[INW-1];
                    mag_d  = sign_d ? -in_data : in_data;
                    exp_d  = NX'(EXP_INIT);
                    if (in_data == '0) begin
                        out_data_d    = '0;
                        out_inexact_d = 1'b0;
                        state_d       = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[INW-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - NX'(1);
                end
            end
            ROUND: begin
                word_c.sign   = sign_q;
                word_c.exp    = exp_q + NX'(carry_c);
                word_c.mant   = m_rnd_c;
                out_data_d    = word_c;
                out_inexact_d = inexact_c;
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            mag_q         <= '0;
            exp_q         <= '0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            mag_q         <= mag_d;
            exp_q         <= exp_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_from_int.sv
// Randomised bench for fp_from_int (signed and unsigned instances) against an
// arithmetic reference model of int-to-binary32 conversion.
module tb_fp_from_int;

    logic        CLK;
    logic        RST_N;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_inexact;
    logic [31:0] s_in_data, s_out_data;
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_inexact;
    logic [31:0] u_in_data, u_out_data;

    int n_chk;
    int n_pass;

    fp_from_int #(.INW(32), .SIGNED(1'b1), .NX(8), .NM(23)) u_dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .in_data     (s_in_data),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready),
        .out_data    (s_out_data),
        .out_inexact (s_out_inexact)
    );

    fp_from_int #(.INW(32), .SIGNED(1'b0), .NX(8), .NM(23)) u_dut_u (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_valid    (u_in_valid),
        .in_ready    (u_in_ready),
        .in_data     (u_in_data),
        .out_valid   (u_out_valid),
        .out_ready   (u_out_ready),
        .out_data    (u_out_data),
        .out_inexact (u_out_inexact)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    endtask

    // Reference: exact magnitude, leading-one position, RNE by remainder vs half-ulp.
    function automatic void ref_conv(input logic [31:0] v, input bit sgn,
                                     output logic [31:0] res, output bit inex, output int lat);
        longint unsigned mag, q, rem, half;
        int p, e, sh;
        bit s;
        s    = sgn && v[31];
        mag  = s ? (64'd4294967296 - 64'(v)) : 64'(v);
        inex = 1'b0;
        res  = 32'd0;
        lat  = 1;
        if (mag == 0) return;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        e   = 127 + p;
        lat = 31 - p + 3;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            inex = (rem != 0);
        end
        if (q >= 64'd16777216) begin
            q = q >> 1;
            e++;
        end
        res = {s, 8'(e), 23'(q)};
    endfunction

    function automatic bit cur_valid(input bit use_u);
        return use_u ? u_out_valid : s_out_valid;
    endfunction

    // One conversion with out_ready high; checks latency, data and inexact.
    task automatic run_one(input bit use_u, input logic [31:0] v);
        logic [31:0] exp_res;
        bit          exp_inex;
        int          exp_lat;
        int          n;
        ref_conv(v, !use_u, exp_res, exp_inex, exp_lat);
        n = 0;
        while (!(use_u ? u_in_ready : s_in_ready) && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        if (use_u) begin u_in_valid = 1'b1; u_in_data = v; end
        else begin s_in_valid = 1'b1; s_in_data = v; end
        @(posedge CLK); #1;
        s_in_valid = 1'b0; u_in_valid = 1'b0;
        s_in_data  = $urandom; u_in_data = $urandom;
        n = 1;
        while (!cur_valid(use_u) && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        chk($sformatf("latency u=%0d v=%08h", use_u, v), 64'(n), 64'(exp_lat));
        chk($sformatf("data u=%0d v=%08h", use_u, v),
            64'(use_u ? u_out_data : s_out_data), 64'(exp_res));
        chk($sformatf("inexact u=%0d v=%08h", use_u, v),
            64'(use_u ? u_out_inexact : s_out_inexact), 64'(exp_inex));
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] r1, r2;
        bit          i1, i2;
        int          l1, l2;
        int          n, bad;
        logic [31:0] v;

        n_chk = 0; n_pass = 0;
        RST_N = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst in_ready", 64'(s_in_ready), 64'd1);
        chk("rst out_valid", 64'(s_out_valid), 64'd0);
        chk("rst out_data", 64'(s_out_data), 64'd0);
        chk("rst out_inexact", 64'(s_out_inexact), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Directed values from the signed instance.
        run_one(1'b0, 32'd1);
        run_one(1'b0, 32'hFFFFFFFF);
        run_one(1'b0, 32'd0);
        run_one(1'b0, 32'd16777217);
        run_one(1'b0, 32'd16777219);
        run_one(1'b0, 32'd16777221);
        run_one(1'b0, 32'h7FFFFFFF);
        run_one(1'b0, 32'h80000000);
        run_one(1'b0, 32'h40000000);
        run_one(1'b0, 32'hFF000001);
        // Directed values from the unsigned instance.
        run_one(1'b1, 32'h80000000);
        run_one(1'b1, 32'hFFFFFFFF);
        run_one(1'b1, 32'd1);
        run_one(1'b1, 32'd0);

        for (int k = 0; k < 20; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            run_one(1'b0, v);
        end
        for (int k = 0; k < 10; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            run_one(1'b1, v);
        end

        // Back-pressure: result held, second input blocked until release.
        ref_conv(32'd16777219, 1'b1, r1, i1, l1);
        ref_conv(32'hFFFFFF00, 1'b1, r2, i2, l2);
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'd16777219;
        @(posedge CLK); #1;
        s_in_valid = 1'b0;
        n = 1;
        while (!s_out_valid && n < 100) begin @(posedge CLK); #1; n++; end
        chk("bp first data", 64'(s_out_data), 64'(r1));
        for (int k = 0; k < 10; k++) begin
            s_in_valid = 1'b1; s_in_data = 32'hFFFFFF00;
            @(posedge CLK); #1;
            chk($sformatf("bp hold data c%0d", k), 64'(s_out_data), 64'(r1));
            chk($sformatf("bp hold valid c%0d", k), 64'(s_out_valid), 64'd1);
            chk($sformatf("bp in_ready c%0d", k), 64'(s_in_ready), 64'd0);
        end
        s_out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("bp release in_ready", 64'(s_in_ready), 64'd1);
        chk("bp release out_valid", 64'(s_out_valid), 64'd0);
        @(posedge CLK); #1;
        s_in_valid = 1'b0;
        n = 1;
        while (!s_out_valid && n < 100) begin @(posedge CLK); #1; n++; end
        chk("bp second latency", 64'(n), 64'(l2));
        chk("bp second data", 64'(s_out_data), 64'(r2));
        chk("bp second inexact", 64'(s_out_inexact), 64'(i2));
        @(posedge CLK); #1;

        // Reset in the middle of normalisation drops the conversion.
        s_in_valid = 1'b1; s_in_data = 32'd1;
        @(posedge CLK); #1;
        s_in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        chk("midrst in_ready", 64'(s_in_ready), 64'd1);
        chk("midrst out_valid", 64'(s_out_valid), 64'd0);
        chk("midrst out_data", 64'(s_out_data), 64'd0);
        bad = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (s_out_valid) bad++;
        end
        chk("midrst no stale result", 64'(bad), 64'd0);
        run_one(1'b0, 32'd16777221);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
